// File: rtl/disk_pkg.sv
// Shared types and command-word layout for the disk sector-transfer engine.
package disk_pkg;

  localparam int DEFAULT_SECTOR_WORDS = 512;

  localparam int CMD_WRITE_BIT  = 31;
  localparam int CMD_SEL_BIT    = 30;
  localparam int CMD_SECTOR_MSB = 29;
  localparam int CMD_SECTOR_LSB = 0;
  localparam int SECTOR_W       = CMD_SECTOR_MSB - CMD_SECTOR_LSB + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_WR_FETCH,
    ST_WR_REQ,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sector_buffer.sv
// True dual-port 32-bit sector RAM, registered read on both ports.
module sector_buffer
  import disk_pkg::*;
#(
  parameter int DEPTH = DEFAULT_SECTOR_WORDS,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] i_a_addr,
  input  logic          i_a_we,
  input  logic [31:0]   i_a_wdata,
  output logic [31:0]   o_a_rdata,
  input  logic [AW-1:0] i_b_addr,
  input  logic          i_b_we,
  input  logic [31:0]   i_b_wdata,
  output logic [31:0]   o_b_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_a_q;
  logic [31:0] r_b_q;

  // Colliding writes from both ports leave the word undefined; port B happens to win here.
  always_ff @(posedge clk) begin
    if (i_a_we) r_mem[i_a_addr] <= i_a_wdata;
    if (i_b_we) r_mem[i_b_addr] <= i_b_wdata;
    r_a_q <= r_mem[i_a_addr];
    r_b_q <= r_mem[i_b_addr];
  end

  assign o_a_rdata = r_a_q;
  assign o_b_rdata = r_b_q;

endmodule

// File: rtl/disk_ctrl.sv
// Moves one sector between the local sector buffer and the backing store
// over a req/ack interface, started by strobe edges from the disk port.
module disk_ctrl
  import disk_pkg::*;
#(
  parameter int SECTOR_WORDS = DEFAULT_SECTOR_WORDS,
  parameter int NUM_SECTORS  = 2048,
  parameter int MEM_AW       = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [31:0]                     instruction,
  input  logic                            write_pause,
  input  logic                            read_pause,
  output logic                            disk_operate_done,
  output logic                            disk_error,
  input  logic [$clog2(SECTOR_WORDS)-1:0] disk_addr,
  input  logic [31:0]                     disk_data_out,
  input  logic                            buf_we,
  output logic [31:0]                     disk_data_in,
  output logic                            mem_req,
  output logic                            mem_we,
  output logic [MEM_AW-1:0]               mem_addr,
  output logic [31:0]                     mem_wdata,
  input  logic [31:0]                     mem_rdata,
  input  logic                            mem_ack
);

  localparam int               IDX_W    = $clog2(SECTOR_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SECTOR_WORDS - 1);

  // IDLE wait start | RD_REQ fetch word from store | WR_FETCH read buffer | WR_REQ store word | DONE pulse
  state_t r_state, w_state_nxt;

  logic                r_rd_pause_d, r_wr_pause_d;
  logic [SECTOR_W-1:0] r_sector, w_sector_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic                r_done, w_done_nxt;
  logic                r_err, w_err_nxt;
  logic                r_mem_req, w_mem_req_nxt;
  logic                r_mem_we, w_mem_we_nxt;
  logic [MEM_AW-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic [31:0]         r_mem_wdata, w_mem_wdata_nxt;

  logic                w_rd_edge, w_wr_edge, w_start, w_cmd_bad;
  logic [SECTOR_W-1:0] w_cmd_sector;
  logic [IDX_W-1:0]    w_buf_addr;
  logic                w_buf_we;
  logic [31:0]         w_buf_q;
  logic                w_unused;

  // Direction comes from which strobe fired; the command's write flag is redundant with it.
  assign w_unused     = instruction[CMD_WRITE_BIT];
  assign w_rd_edge    = read_pause & ~r_rd_pause_d;
  assign w_wr_edge    = write_pause & ~r_wr_pause_d;
  assign w_start      = (r_state == ST_IDLE) & instruction[CMD_SEL_BIT] & (w_rd_edge | w_wr_edge);
  assign w_cmd_sector = instruction[CMD_SECTOR_MSB:CMD_SECTOR_LSB];
  assign w_cmd_bad    = {2'b00, w_cmd_sector} >= 32'(NUM_SECTORS);

  function automatic logic [MEM_AW-1:0] f_word_addr(input logic [SECTOR_W-1:0] sector,
                                                    input logic [IDX_W-1:0]    idx);
    return MEM_AW'(sector) * MEM_AW'(SECTOR_WORDS) + MEM_AW'(idx);
  endfunction

  // Port B looks at the next index so the fetched word is ready in WR_FETCH.
  assign w_buf_we   = (r_state == ST_RD_REQ) & mem_ack;
  assign w_buf_addr = (r_state == ST_RD_REQ) ? r_idx : w_idx_nxt;

  sector_buffer #(.DEPTH(SECTOR_WORDS)) u_buf (
    .clk       (clk),
    .i_a_addr  (disk_addr),
    .i_a_we    (buf_we),
    .i_a_wdata (disk_data_out),
    .o_a_rdata (disk_data_in),
    .i_b_addr  (w_buf_addr),
    .i_b_we    (w_buf_we),
    .i_b_wdata (mem_rdata),
    .o_b_rdata (w_buf_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_rd_pause_d <= 1'b0;
      r_wr_pause_d <= 1'b0;
      r_sector     <= '0;
      r_idx        <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_rd_pause_d <= read_pause;
      r_wr_pause_d <= write_pause;
      r_sector     <= w_sector_nxt;
      r_idx        <= w_idx_nxt;
      r_done       <= w_done_nxt;
      r_err        <= w_err_nxt;
      r_mem_req    <= w_mem_req_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_sector_nxt    = r_sector;
    w_idx_nxt       = r_idx;
    w_err_nxt       = r_err;
    w_done_nxt      = 1'b0;
    w_mem_req_nxt   = 1'b0;
    w_mem_we_nxt    = 1'b0;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_sector_nxt = w_cmd_sector;
          w_idx_nxt    = '0;
          w_err_nxt    = 1'b0;
          if (w_cmd_bad) begin
            w_state_nxt = ST_DONE;
            w_err_nxt   = 1'b1;
            w_done_nxt  = 1'b1;
          end else if (w_wr_edge) begin
            w_state_nxt = ST_WR_FETCH;
          end else begin
            w_state_nxt    = ST_RD_REQ;
            w_mem_req_nxt  = 1'b1;
            w_mem_addr_nxt = f_word_addr(w_cmd_sector, '0);
          end
        end
      end
      ST_RD_REQ: begin
        w_mem_req_nxt = 1'b1;
        if (mem_ack) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt   = ST_DONE;
            w_done_nxt    = 1'b1;
            w_mem_req_nxt = 1'b0;
          end else begin
            w_idx_nxt      = r_idx + 1'b1;
            w_mem_addr_nxt = f_word_addr(r_sector, r_idx + 1'b1);
          end
        end
      end
      ST_WR_FETCH: begin
        w_state_nxt     = ST_WR_REQ;
        w_mem_req_nxt   = 1'b1;
        w_mem_we_nxt    = 1'b1;
        w_mem_addr_nxt  = f_word_addr(r_sector, r_idx);
        w_mem_wdata_nxt = w_buf_q;
      end
      ST_WR_REQ: begin
        w_mem_req_nxt = 1'b1;
        w_mem_we_nxt  = 1'b1;
        if (mem_ack) begin
          w_mem_req_nxt = 1'b0;
          w_mem_we_nxt  = 1'b0;
          if (r_idx == LAST_IDX) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_WR_FETCH;
            w_idx_nxt   = r_idx + 1'b1;
          end
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign disk_operate_done = r_done;
  assign disk_error        = r_err;
  assign mem_req           = r_mem_req;
  assign mem_we            = r_mem_we;
  assign mem_addr          = r_mem_addr;
  assign mem_wdata         = r_mem_wdata;

endmodule

// File: tb/tb_disk_ctrl.sv
// Bench for disk_ctrl: randomized sector transfers against a behavioural store/buffer model.
module tb_disk_ctrl;

  localparam int SW = 512;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instruction = '0;
  logic        write_pause = 1'b0;
  logic        read_pause = 1'b0;
  logic        disk_operate_done;
  logic        disk_error;
  logic [8:0]  disk_addr = '0;
  logic [31:0] disk_data_out = '0;
  logic        buf_we = 1'b0;
  logic [31:0] disk_data_in;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [31:0] store [logic [31:0]];
  logic [31:0] model_buf [SW];

  logic [31:0] t_addr [$];
  bit          t_we [$];
  logic [31:0] t_wd [$];
  int          t_cyc [$];
  int          q_done [$];
  bit          q_err [$];
  int          unstable = 0;
  int          waits = 0;
  int          wcnt = 0;
  logic [31:0] hold_addr, hold_wd;
  logic        hold_we;

  disk_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .instruction       (instruction),
    .write_pause       (write_pause),
    .read_pause        (read_pause),
    .disk_operate_done (disk_operate_done),
    .disk_error        (disk_error),
    .disk_addr         (disk_addr),
    .disk_data_out     (disk_data_out),
    .buf_we            (buf_we),
    .disk_data_in      (disk_data_in),
    .mem_req           (mem_req),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_rdata         (mem_rdata),
    .mem_ack           (mem_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] store_rd(input logic [31:0] a);
    if (store.exists(a)) return store[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  // Backing-store responder with programmable wait states; logs every completed request.
  always @(negedge clk) begin
    if (disk_operate_done) begin
      q_done.push_back(cyc);
      q_err.push_back(disk_error);
    end
    if (rst || !mem_req) begin
      mem_ack = 1'b0;
      wcnt = 0;
    end else begin
      if (wcnt == 0) begin
        hold_addr = mem_addr; hold_we = mem_we; hold_wd = mem_wdata;
      end else if (mem_addr !== hold_addr || mem_we !== hold_we || (mem_we && mem_wdata !== hold_wd)) begin
        unstable++;
      end
      if (wcnt >= waits) begin
        mem_ack = 1'b1;
        wcnt = 0;
        t_addr.push_back(mem_addr);
        t_we.push_back(mem_we);
        t_wd.push_back(mem_wdata);
        t_cyc.push_back(cyc);
        if (mem_we) store[mem_addr] = mem_wdata;
        else mem_rdata = store_rd(mem_addr);
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end
  end

  task automatic clear_logs;
    t_addr.delete(); t_we.delete(); t_wd.delete(); t_cyc.delete();
    q_done.delete(); q_err.delete();
    unstable = 0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic start_cmd(input logic [31:0] ins, input bit rd, input bit wr, input bit hold, output int s);
    @(negedge clk);
    instruction = ins;
    read_pause  = rd;
    write_pause = wr;
    s = cyc;
    if (!hold) begin
      @(negedge clk);
      read_pause  = 1'b0;
      write_pause = 1'b0;
    end
    #1;
  endtask

  task automatic wait_done(input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (q_done.size() > 0) break;
      @(negedge clk);
      #1;
    end
    if (q_done.size() > 0) to = 1'b0;
  endtask

  task automatic bus_write_all;
    for (int i = 0; i < SW; i++) begin
      @(negedge clk);
      buf_we = 1'b1; disk_addr = 9'(i); disk_data_out = model_buf[i];
    end
    @(negedge clk);
    buf_we = 1'b0;
  endtask

  task automatic test_reset;
    wait_cycles(3);
    n_vec++; if (disk_operate_done !== 1'b0) begin n_err++; $display("FAIL rst_done got=%b want=0", disk_operate_done); end
    n_vec++; if (disk_error !== 1'b0) begin n_err++; $display("FAIL rst_err got=%b want=0", disk_error); end
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got=%b want=0", mem_req); end
    n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rst_we got=%b want=0", mem_we); end
    n_vec++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr got=%h want=0", mem_addr); end
    n_vec++; if (mem_wdata !== 32'h0) begin n_err++; $display("FAIL rst_wdata got=%h want=0", mem_wdata); end
    @(negedge clk);
    rst = 1'b0;
    wait_cycles(3);
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_idle_req got=%b want=0", mem_req); end
  endtask

  task automatic test_read_zero_wait;
    int s; bit to; logic [31:0] base; logic [31:0] got;
    base = 32'd3 * SW;
    for (int k = 0; k < SW; k++) store[base + 32'(k)] = 32'h0300_0000 + 32'(k);
    waits = 0;
    clear_logs();
    start_cmd(32'h4000_0003, 1'b1, 1'b0, 1'b0, s);
    wait_done(3 * SW, to);
    n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL rd0_timeout got=%b want=0", to); end
    n_vec++; if (t_addr.size() !== SW) begin n_err++; $display("FAIL rd0_count got=%0d want=%0d", t_addr.size(), SW); end
    for (int k = 0; k < t_addr.size(); k++) begin
      n_vec++;
      if (t_addr[k] !== base + 32'(k) || t_we[k] !== 1'b0) begin
        n_err++; $display("FAIL rd0_addr[%0d] got=%h/we%b want=%h/we0", k, t_addr[k], t_we[k], base + 32'(k));
      end
    end
    if (t_cyc.size() > 0) begin
      n_vec++; if (t_cyc[0] !== s + 1) begin n_err++; $display("FAIL rd0_first_req got=%0d want=%0d", t_cyc[0], s + 1); end
    end
    n_vec++; if (q_done.size() !== 1) begin n_err++; $display("FAIL rd0_done_count got=%0d want=1", q_done.size()); end
    if (q_done.size() > 0) begin
      n_vec++; if (q_done[0] !== s + 1 + SW) begin n_err++; $display("FAIL rd0_done_cyc got=%0d want=%0d", q_done[0], s + 1 + SW); end
      n_vec++; if (q_err[0] !== 1'b0) begin n_err++; $display("FAIL rd0_err got=%b want=0", q_err[0]); end
    end
    for (int k = 0; k < SW; k++) model_buf[k] = store_rd(base + 32'(k));
    @(negedge clk); disk_addr = 9'd5;
    @(negedge clk); #1; got = disk_data_in;
    n_vec++; if (got !== 32'h0300_0005) begin n_err++; $display("FAIL rd0_bus5 got=%h want=03000005", got); end
  endtask

  task automatic test_read_random;
    int s; bit to; int sector; logic [31:0] base;
    for (int it = 0; it < 2; it++) begin
      sector = int'($urandom_range(0, 2047));
      waits  = int'($urandom_range(0, 2));
      base   = 32'(sector) * SW;
      clear_logs();
      start_cmd(32'h4000_0000 | 32'(sector), 1'b1, 1'b0, 1'b0, s);
      wait_done(4 * SW, to);
      n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL rdr_timeout got=%b want=0", to); end
      n_vec++; if (t_addr.size() !== SW) begin n_err++; $display("FAIL rdr_count got=%0d want=%0d", t_addr.size(), SW); end
      for (int k = 0; k < t_addr.size(); k++) begin
        n_vec++;
        if (t_addr[k] !== base + 32'(k)) begin n_err++; $display("FAIL rdr_addr[%0d] got=%h want=%h", k, t_addr[k], base + 32'(k)); end
      end
      n_vec++; if (unstable !== 0) begin n_err++; $display("FAIL rdr_stable got=%0d want=0", unstable); end
      if (q_done.size() > 0) begin
        n_vec++;
        if (q_done[0] !== s + 1 + (waits + 1) * SW) begin
          n_err++; $display("FAIL rdr_done_cyc got=%0d want=%0d", q_done[0], s + 1 + (waits + 1) * SW);
        end
      end
      for (int k = 0; k < SW; k++) model_buf[k] = store_rd(base + 32'(k));
      @(negedge clk); disk_addr = '0;
      for (int i = 0; i < SW; i++) begin
        @(negedge clk); #1;
        n_vec++;
        if (disk_data_in !== model_buf[i]) begin n_err++; $display("FAIL rdr_bus[%0d] got=%h want=%h", i, disk_data_in, model_buf[i]); end
        disk_addr = 9'(i + 1);
      end
    end
  endtask

  task automatic test_write(input bit pattern, input int sector, input int w);
    int s; bit to; logic [31:0] base;
    for (int i = 0; i < SW; i++) model_buf[i] = pattern ? (32'(i) ^ 32'hA5A5) : $urandom();
    bus_write_all();
    waits = w;
    base = 32'(sector) * SW;
    clear_logs();
    start_cmd(32'hC000_0000 | 32'(sector), 1'b0, 1'b1, 1'b0, s);
    wait_done(5 * SW, to);
    n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL wr_timeout got=%b want=0", to); end
    n_vec++; if (t_addr.size() !== SW) begin n_err++; $display("FAIL wr_count got=%0d want=%0d", t_addr.size(), SW); end
    for (int k = 0; k < t_addr.size(); k++) begin
      n_vec++;
      if (t_addr[k] !== base + 32'(k) || t_we[k] !== 1'b1 || t_wd[k] !== model_buf[k]) begin
        n_err++; $display("FAIL wr_word[%0d] got=%h:%h/we%b want=%h:%h/we1", k, t_addr[k], t_wd[k], t_we[k], base + 32'(k), model_buf[k]);
      end
    end
    n_vec++; if (unstable !== 0) begin n_err++; $display("FAIL wr_stable got=%0d want=0", unstable); end
    wait_cycles(5);
    n_vec++; if (q_done.size() !== 1) begin n_err++; $display("FAIL wr_done_count got=%0d want=1", q_done.size()); end
    if (q_done.size() > 0) begin
      n_vec++;
      if (q_done[0] !== s + 1 + (w + 2) * SW) begin n_err++; $display("FAIL wr_done_cyc got=%0d want=%0d", q_done[0], s + 1 + (w + 2) * SW); end
    end
  endtask

  task automatic test_out_of_range;
    int s; bit to; int sector;
    waits = 0;
    clear_logs();
    start_cmd(32'h4000_0800, 1'b1, 1'b0, 1'b0, s);
    wait_done(10, to);
    n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL oor_timeout got=%b want=0", to); end
    if (q_done.size() > 0) begin
      n_vec++; if (q_done[0] !== s + 1) begin n_err++; $display("FAIL oor_done_cyc got=%0d want=%0d", q_done[0], s + 1); end
      n_vec++; if (q_err[0] !== 1'b1) begin n_err++; $display("FAIL oor_err got=%b want=1", q_err[0]); end
    end
    wait_cycles(5);
    n_vec++; if (t_addr.size() !== 0) begin n_err++; $display("FAIL oor_traffic got=%0d want=0", t_addr.size()); end
    n_vec++; if (disk_error !== 1'b1) begin n_err++; $display("FAIL oor_err_hold got=%b want=1", disk_error); end
    sector = int'($urandom_range(2048, 32'h3FFF_FFFF));
    clear_logs();
    start_cmd(32'hC000_0000 | 32'(sector), 1'b0, 1'b1, 1'b0, s);
    wait_done(10, to);
    wait_cycles(3);
    n_vec++; if (t_addr.size() !== 0 || q_done.size() !== 1) begin n_err++; $display("FAIL oor_wr got=%0d/%0d want=0/1", t_addr.size(), q_done.size()); end
    n_vec++; if (disk_error !== 1'b1) begin n_err++; $display("FAIL oor_wr_err got=%b want=1", disk_error); end
    sector = int'($urandom_range(0, 2047));
    clear_logs();
    start_cmd(32'h4000_0000 | 32'(sector), 1'b1, 1'b0, 1'b0, s);
    n_vec++; if (disk_error !== 1'b0) begin n_err++; $display("FAIL oor_clear got=%b want=0", disk_error); end
    wait_done(3 * SW, to);
    n_vec++; if (to !== 1'b0 || q_err.size() < 1 || q_err[0] !== 1'b0) begin n_err++; $display("FAIL oor_next got=to%b want=to0 err0", to); end
    for (int k = 0; k < SW; k++) model_buf[k] = store_rd(32'(sector) * SW + 32'(k));
  endtask

  task automatic test_ignored;
    int s; bit to;
    waits = 0;
    clear_logs();
    start_cmd(32'h0000_0003, 1'b1, 1'b0, 1'b0, s);
    wait_cycles(20);
    n_vec++; if (t_addr.size() !== 0 || q_done.size() !== 0) begin n_err++; $display("FAIL ign_nosel got=%0d/%0d want=0/0", t_addr.size(), q_done.size()); end
    clear_logs();
    start_cmd(32'hC000_0004, 1'b0, 1'b1, 1'b0, s);
    wait_cycles(100);
    start_cmd(32'h4000_0005, 1'b1, 1'b0, 1'b0, s);
    wait_done(3 * SW, to);
    wait_cycles(20);
    n_vec++; if (q_done.size() !== 1) begin n_err++; $display("FAIL ign_midwr_done got=%0d want=1", q_done.size()); end
    n_vec++; if (t_addr.size() !== SW) begin n_err++; $display("FAIL ign_midwr_count got=%0d want=%0d", t_addr.size(), SW); end
    for (int k = 0; k < t_addr.size(); k++) begin
      n_vec++;
      if (t_we[k] !== 1'b1 || t_addr[k] !== 32'd2048 + 32'(k)) begin
        n_err++; $display("FAIL ign_midwr[%0d] got=%h/we%b want=%h/we1", k, t_addr[k], t_we[k], 32'd2048 + 32'(k));
      end
    end
    clear_logs();
    start_cmd(32'h4000_0006, 1'b1, 1'b0, 1'b1, s);
    wait_done(3 * SW, to);
    wait_cycles(30);
    n_vec++; if (q_done.size() !== 1 || t_addr.size() !== SW) begin n_err++; $display("FAIL ign_held got=%0d/%0d want=1/%0d", q_done.size(), t_addr.size(), SW); end
    @(negedge clk); read_pause = 1'b0;
    for (int k = 0; k < SW; k++) model_buf[k] = store_rd(32'd6 * SW + 32'(k));
  endtask

  task automatic test_simultaneous;
    int s; bit to;
    waits = 0;
    clear_logs();
    start_cmd(32'h4000_0002, 1'b1, 1'b1, 1'b0, s);
    wait_done(3 * SW, to);
    n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL sim_timeout got=%b want=0", to); end
    n_vec++; if (t_addr.size() !== SW) begin n_err++; $display("FAIL sim_count got=%0d want=%0d", t_addr.size(), SW); end
    for (int k = 0; k < t_addr.size(); k++) begin
      n_vec++;
      if (t_we[k] !== 1'b1 || t_wd[k] !== model_buf[k]) begin
        n_err++; $display("FAIL sim_word[%0d] got=%h/we%b want=%h/we1", k, t_wd[k], t_we[k], model_buf[k]);
      end
    end
    if (q_done.size() > 0) begin
      n_vec++; if (q_done[0] !== s + 1 + 2 * SW) begin n_err++; $display("FAIL sim_done_cyc got=%0d want=%0d", q_done[0], s + 1 + 2 * SW); end
    end
  endtask

  task automatic test_reset_mid_read;
    int s; bit to;
    waits = 0;
    clear_logs();
    start_cmd(32'h4000_0007, 1'b1, 1'b0, 1'b0, s);
    for (int i = 0; i < 400 && t_addr.size() < 200; i++) @(negedge clk);
    n_vec++; if (t_addr.size() < 200) begin n_err++; $display("FAIL rstm_progress got=%0d want>=200", t_addr.size()); end
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    n_vec++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin n_err++; $display("FAIL rstm_req got=%b%b want=00", mem_req, mem_we); end
    n_vec++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin n_err++; $display("FAIL rstm_bus got=%h/%h want=0/0", mem_addr, mem_wdata); end
    n_vec++; if (disk_operate_done !== 1'b0 || disk_error !== 1'b0) begin n_err++; $display("FAIL rstm_flags got=%b%b want=00", disk_operate_done, disk_error); end
    @(negedge clk);
    rst = 1'b0;
    wait_cycles(10);
    n_vec++; if (q_done.size() !== 0) begin n_err++; $display("FAIL rstm_nodone got=%0d want=0", q_done.size()); end
    clear_logs();
    start_cmd(32'h4000_0009, 1'b1, 1'b0, 1'b0, s);
    wait_done(3 * SW, to);
    n_vec++; if (t_addr.size() !== SW) begin n_err++; $display("FAIL rstm_next_count got=%0d want=%0d", t_addr.size(), SW); end
    if (t_addr.size() > 0) begin
      n_vec++; if (t_addr[0] !== 32'd9 * SW) begin n_err++; $display("FAIL rstm_next_addr0 got=%h want=%h", t_addr[0], 32'd9 * SW); end
    end
    if (q_done.size() > 0) begin
      n_vec++; if (q_done[0] !== s + 1 + SW) begin n_err++; $display("FAIL rstm_next_done got=%0d want=%0d", q_done[0], s + 1 + SW); end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_read_zero_wait();
    test_read_random();
    test_write(1'b1, 1, 2);
    test_write(1'b0, int'($urandom_range(0, 2047)), int'($urandom_range(0, 1)));
    test_out_of_range();
    test_ignored();
    test_simultaneous();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/disk_ctrl.md
# disk_ctrl

Sector-transfer engine between the memory-mapped disk port and the backing block store. Owns the 512-word sector buffer, decodes the command word and start strobes issued by the bus-facing disk port, and moves one whole sector between the buffer and the backing store over a req/ack memory interface. Completion is reported to the disk port as a single-cycle `disk_operate_done` pulse.

## Interface
- `SECTOR_WORDS`, 512: words per sector; buffer depth. Must be a power of two.
- `NUM_SECTORS`, 2048: valid sector count. Commands at or above this value fail.
- `MEM_AW`, 32: backing-store word-address width.
- `clk` input 1: system clock.
- `rst` input 1: reset, asynchronous, active-high.
- `instruction` input 32: command word. [31] write=1/read=0; [30] command-register select; [29:0] sector number.
- `write_pause` input 1: write-start strobe from the disk port.
- `read_pause` input 1: read-start strobe from the disk port.
- `disk_operate_done` output 1: one-cycle completion pulse.
- `disk_error` output 1: sticky error for the last command.
- `disk_addr` input 9: bus-side buffer word index.
- `disk_data_out` input 32: bus write data into the buffer.
- `buf_we` input 1: bus-side buffer write enable.
- `disk_data_in` output 32: bus-side buffer read data, registered.
- `mem_req` output 1: backing-store request.
- `mem_we` output 1: request is a write.
- `mem_addr` output MEM_AW: word address.
- `mem_wdata` output 32: write data.
- `mem_rdata` input 32: read data, valid with `mem_ack`.
- `mem_ack` input 1: request completes this cycle.

## Operation
- States: IDLE, RD_REQ, WR_FETCH, WR_REQ, DONE.
- Start detection:
  - Rising edge of `read_pause` or `write_pause` (compared with a registered copy) while in IDLE, with `instruction[30]`=1.
  - Edges outside IDLE are ignored.
  - If both edges occur in the same cycle, write wins.
- Latch `sector = instruction[29:0]`, clear `disk_error`, reset word counter `idx` to 0.
- If `sector >= NUM_SECTORS`, go straight to DONE with `disk_error`=1. No memory traffic.
- Read path (RD_REQ):
  - `mem_req`=1, `mem_we`=0, `mem_addr = sector*SECTOR_WORDS + idx`.
  - On `mem_ack`, write `mem_rdata` to `buf[idx]`.
  - If `idx`=SECTOR_WORDS-1, go to DONE; else increment `idx` and stay.
- Write path:
  - WR_FETCH: read `buf[idx]` on the internal port (1-cycle latency).
  - WR_REQ: `mem_req`=1, `mem_we`=1, `mem_wdata` = fetched word.
  - On `mem_ack`, go to DONE if last word, else to WR_FETCH with `idx+1`.
- DONE: assert `disk_operate_done` for exactly one cycle, then return to IDLE.
- Address arithmetic is done at MEM_AW bits; sector is zero-extended, and the product truncates silently.
- Buffer is true dual-port.
  - Bus port: write when `buf_we`, read data on `disk_data_in` one cycle after `disk_addr`.
  - Bus access during an active transfer is performed. Contents at colliding indices are undefined; software must not do this.

## Timing
- Reset values:
  - State IDLE.
  - `disk_operate_done`, `disk_error`, `mem_req`, `mem_we` = 0.
  - `mem_addr`, `mem_wdata` = 0.
  - `idx` = 0; strobe history registers = 0.
  - Buffer contents are not reset.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are registered. They are stable from assertion until the cycle `mem_ack` is sampled high.
- Start edge at cycle N gives `mem_req` high at N+1.
- Read transfers:
  - A read issues back-to-back requests: with zero-wait ack, `mem_req` stays high and `mem_addr` advances every cycle.
  - Read of a full sector with zero-wait ack: `disk_operate_done` at N+1+SECTOR_WORDS.
- Write transfers:
  - A write inserts one WR_FETCH cycle per word.
  - Full-sector write with zero-wait ack: done at N+1+2*SECTOR_WORDS.
- Error command: done pulse at N+1.
- `disk_error` updates in the same cycle as the done pulse. It holds until the next accepted start.
- If `rst` asserts mid-transfer, everything returns to IDLE immediately. No done pulse is emitted. A partial sector may already be in the store or the buffer.

## Structure
- Shared package `disk_pkg`:
  - state enum;
  - command-word field positions (`CMD_WRITE_BIT`=31, `CMD_SEL_BIT`=30, sector field 29:0);
  - default `SECTOR_WORDS`.
- Sub-module `sector_buffer`: parameterised dual-port 32-bit RAM with registered read on both ports, inferred as block RAM.

## Test plan
- Read, zero-wait: store word `k` of sector 3 holds `0x0300_0000+k`; rising `read_pause` with `instruction=0x4000_0003` → `mem_addr` 1536..2047; done pulse 513 cycles later; bus reads `disk_addr=5` → `0x0300_0005`.
- Write with 2-wait-state ack: bus fills buffer index i with `i^0xA5A5`; `write_pause` edge with `instruction=0xC000_0001` → store 512..1023 receives those values in order; `mem_wdata` stable through each wait; exactly one done pulse.
- Out of range: `instruction=0x4000_0800` → no `mem_req`, done at N+1, `disk_error`=1; the next valid command clears it.
- Ignored starts:
  - `instruction[30]`=0 → nothing happens.
  - A `read_pause` edge mid-write is not accepted and causes no second done pulse.
  - A held-high strobe is not re-triggered.
- Simultaneous `read_pause`/`write_pause` edges → write performed (`mem_we`=1).
- Reset at word 200 of a read → outputs return to reset values in the same cycle; no done pulse; the next command then runs normally from `idx`=0.
